netbus_tx3: RTL and testbench

// - Transmit-side frame router: accepts one NetBus flit stream and steers whole frames to one of three output ports.
// - Destination is taken from the header flit. Frames with no matching destination are consumed and dropped.
// - Single clock domain. Sits upstream of per-link CDC/receive slices; output ports feed link transmit slices.
// - Frames never interleave on a port. One input frame is in flight at a time.

---
 rtl/netbus_pkg.sv | 24 ++
 rtl/netbus_tx_skid.sv | 52 +++++
 rtl/netbus_tx3.sv | 130 +++++++++++++
 tb/tb_netbus_tx3.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/netbus_pkg.sv
// Shared NetBus definitions: flit geometry, header field offsets, router FSM states and port-select type.
package netbus_pkg;

   localparam int DATA_WIDTH_DEF = 4;
   localparam int LAST_BIT       = 0;
   localparam int DEST_LSB       = 1;
   localparam int DEST_W         = 8;
   localparam int NUM_PORTS      = 3;

   function automatic int flit_w(input int data_width);
      return data_width * 9 + 14;
   endfunction

   localparam int FLIT_W = flit_w(DATA_WIDTH_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      DROP = 2'd2
   } state_t;

   typedef logic [1:0] port_sel_t;

endpackage

// File: rtl/netbus_tx_skid.sv
// Two-entry valid/ready register slice. The output and the full flag come straight from registers,
// so the upstream ready never sees a combinational path from i_ready.
module netbus_tx_skid
   import netbus_pkg::*;
#(
   parameter int WIDTH = FLIT_W
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_push,
   output logic             o_full,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   input  logic             i_ready
);

   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] r_tail;
   logic [1:0]       r_count;
   logic             w_pop;
   logic             w_push;

   assign w_pop  = (r_count != 2'd0) && i_ready;
   // A push against a full slice is refused even if a pop frees a slot this cycle.
   assign w_push = i_push && (r_count != 2'd2);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) r_head <= i_data;
               else                 r_tail <= i_data;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_head  <= r_tail;
               r_count <= r_count - 2'd1;
            end
            2'b11: r_head <= i_data;
            default: ;
         endcase
      end
   end

   assign o_full  = (r_count == 2'd2);
   assign o_valid = (r_count != 2'd0);
   assign o_data  = r_head;

endmodule

// File: rtl/netbus_tx3.sv
// Transmit-side frame router: steers whole NetBus frames to one of three ports by header DEST,
// dropping (and counting) frames whose DEST matches no port.
module netbus_tx3
   import netbus_pkg::*;
#(
   parameter int         DATA_WIDTH  = 4,
   parameter logic [7:0] PORT0_ROUTE = 8'h00,
   parameter logic [7:0] PORT1_ROUTE = 8'h01,
   parameter logic [7:0] PORT2_ROUTE = 8'h02
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic [DATA_WIDTH*9+14-1:0]  i_wdata,
   input  logic                        i_wvalid,
   output logic                        o_wready,
   output logic [DATA_WIDTH*9+14-1:0]  o_rdata0,
   output logic                        o_rvalid0,
   input  logic                        i_rready0,
   output logic [DATA_WIDTH*9+14-1:0]  o_rdata1,
   output logic                        o_rvalid1,
   input  logic                        i_rready1,
   output logic [DATA_WIDTH*9+14-1:0]  o_rdata2,
   output logic                        o_rvalid2,
   input  logic                        i_rready2,
   output logic [15:0]                 o_drop_cnt
);

   localparam int W = flit_w(DATA_WIDTH);

   state_t              r_state;
   port_sel_t           r_sel;
   logic [15:0]         r_drop_cnt;

   logic [DEST_W-1:0]   w_dest;
   logic                w_last;
   logic                w_match;
   port_sel_t           w_hdr_sel;
   port_sel_t           w_tgt;
   logic [2:0]          w_full;
   logic [3:0]          w_full_ext;
   logic [2:0]          w_push;
   logic [2:0]          w_rvalid;
   logic [2:0]          w_rready;
   logic [W-1:0]        w_rdata [NUM_PORTS];
   logic                w_ready;
   logic                w_accept;
   logic                w_fwd;

   assign w_dest = i_wdata[DEST_LSB +: DEST_W];
   assign w_last = i_wdata[LAST_BIT];

   // Lower port number wins when route IDs collide.
   always_comb begin
      w_match   = 1'b1;
      w_hdr_sel = 2'd0;
      if (w_dest == PORT0_ROUTE)      w_hdr_sel = 2'd0;
      else if (w_dest == PORT1_ROUTE) w_hdr_sel = 2'd1;
      else if (w_dest == PORT2_ROUTE) w_hdr_sel = 2'd2;
      else                            w_match   = 1'b0;
   end

   assign w_tgt      = (r_state == IDLE) ? w_hdr_sel : r_sel;
   assign w_full_ext = {1'b0, w_full};

   always_comb begin
      w_ready = 1'b1;
      case (r_state)
         IDLE:    w_ready = w_match ? !w_full_ext[w_tgt] : 1'b1;
         FWD:     w_ready = !w_full_ext[w_tgt];
         default: w_ready = 1'b1;
      endcase
   end

   assign o_wready = w_ready && !i_reset;
   assign w_accept = i_wvalid && o_wready;
   assign w_fwd    = w_accept && (((r_state == IDLE) && w_match) || (r_state == FWD));
   assign w_rready = {i_rready2, i_rready1, i_rready0};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         assign w_push[gi] = w_fwd && (w_tgt == port_sel_t'(gi));

         netbus_tx_skid #(
            .WIDTH (W)
         ) u_skid (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_data  (i_wdata),
            .i_push  (w_push[gi]),
            .o_full  (w_full[gi]),
            .o_data  (w_rdata[gi]),
            .o_valid (w_rvalid[gi]),
            .i_ready (w_rready[gi])
         );
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_sel      <= 2'd0;
         r_drop_cnt <= 16'd0;
      end else if (w_accept) begin
         case (r_state)
            IDLE: begin
               if (w_match) begin
                  r_sel <= w_hdr_sel;
                  if (!w_last) r_state <= FWD;
               end else begin
                  if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
                  if (!w_last) r_state <= DROP;
               end
            end
            FWD:     if (w_last) r_state <= IDLE;
            DROP:    if (w_last) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_rdata0   = w_rdata[0];
   assign o_rdata1   = w_rdata[1];
   assign o_rdata2   = w_rdata[2];
   assign o_rvalid0  = w_rvalid[0];
   assign o_rvalid1  = w_rvalid[1];
   assign o_rvalid2  = w_rvalid[2];
   assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_netbus_tx3.sv
// Bench for netbus_tx3: directed scenarios plus random frames, checked every cycle against a
// queue-based model of per-port buffered flits, frame routing state and the drop counter.
module tb_netbus_tx3;

   localparam int W = 4 * 9 + 14;

   logic          clk = 1'b0;
   logic          i_reset;
   logic [W-1:0]  i_wdata;
   logic          i_wvalid;
   logic          o_wready;
   logic [W-1:0]  o_rdata0, o_rdata1, o_rdata2;
   logic          o_rvalid0, o_rvalid1, o_rvalid2;
   logic [2:0]    rready;
   logic [15:0]   o_drop_cnt;

   logic [2:0]    rv;
   logic [W-1:0]  rd [3];

   int            checks = 0;
   int            failures = 0;
   int            stalls = 0;
   int            rr_mode [3];
   int            popped [3];
   logic [W-1:0]  mq [3][$];
   logic [W-1:0]  sent_log [$];
   int            m_state = 0;   // 0: between frames, 1: forwarding, 2: dropping
   int            m_sel = 0;
   int            m_drop = 0;

   always #5 clk = ~clk;

   netbus_tx3 dut (
      .i_clk      (clk),
      .i_reset    (i_reset),
      .i_wdata    (i_wdata),
      .i_wvalid   (i_wvalid),
      .o_wready   (o_wready),
      .o_rdata0   (o_rdata0),
      .o_rvalid0  (o_rvalid0),
      .i_rready0  (rready[0]),
      .o_rdata1   (o_rdata1),
      .o_rvalid1  (o_rvalid1),
      .i_rready1  (rready[1]),
      .o_rdata2   (o_rdata2),
      .o_rvalid2  (o_rvalid2),
      .i_rready2  (rready[2]),
      .o_drop_cnt (o_drop_cnt)
   );

   assign rv    = {o_rvalid2, o_rvalid1, o_rvalid0};
   assign rd[0] = o_rdata0;
   assign rd[1] = o_rdata1;
   assign rd[2] = o_rdata2;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int route(input logic [7:0] d);
      if (d == 8'h00) return 0;
      if (d == 8'h01) return 1;
      if (d == 8'h02) return 2;
      return -1;
   endfunction

   // Output ready generator: 0 = held low, 1 = held high, 2 = random.
   initial begin
      rready = 3'b111;
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 3; k++)
            rready[k] = (rr_mode[k] == 1) ? 1'b1 : (rr_mode[k] == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end

   // Compare and model update, once per cycle on the falling edge.
   initial begin
      int  exp_w;
      int  r;
      logic acc;
      forever begin
         @(negedge clk);
         if (i_reset) exp_w = 0;
         else if (m_state == 1) exp_w = (mq[m_sel].size() < 2) ? 1 : 0;
         else if (m_state == 2) exp_w = 1;
         else begin
            r = route(i_wdata[8:1]);
            exp_w = (r < 0) ? 1 : ((mq[r].size() < 2) ? 1 : 0);
         end
         chk("wready", 64'(o_wready), 64'(exp_w));
         chk("drop_cnt", 64'(o_drop_cnt), 64'(m_drop));
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("rvalid%0d", k), 64'(rv[k]), 64'(mq[k].size() > 0));
            if (mq[k].size() > 0) chk($sformatf("rdata%0d", k), 64'(rd[k]), 64'(mq[k][0]));
         end
         if (i_reset) begin
            for (int k = 0; k < 3; k++) mq[k].delete();
            m_state = 0;
            m_drop  = 0;
         end else begin
            for (int k = 0; k < 3; k++)
               if (mq[k].size() > 0 && rready[k]) begin
                  void'(mq[k].pop_front());
                  popped[k]++;
               end
            acc = i_wvalid && (exp_w == 1);
            if (acc) begin
               if (m_state == 0) begin
                  r = route(i_wdata[8:1]);
                  if (r >= 0) begin
                     mq[r].push_back(i_wdata);
                     m_sel = r;
                     if (!i_wdata[0]) m_state = 1;
                  end else begin
                     if (m_drop < 65535) m_drop++;
                     if (!i_wdata[0]) m_state = 2;
                  end
               end else if (m_state == 1) begin
                  mq[m_sel].push_back(i_wdata);
                  if (i_wdata[0]) m_state = 0;
               end else if (i_wdata[0]) begin
                  m_state = 0;
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] dest, input int len, input int nsend, input int maxgap);
      logic [W-1:0] d;
      logic         rdy;
      int           waitc;
      $display("frame dest=%02h len=%0d flits_sent=%0d", dest, len, nsend);
      for (int i = 0; i < nsend; i++) begin
         d = W'({$urandom(), $urandom()});
         d[0] = (i == len - 1);
         if (i == 0) d[8:1] = dest;
         i_wvalid = 1'b1;
         i_wdata  = d;
         waitc    = 0;
         rdy      = 1'b0;
         do begin
            @(negedge clk);
            rdy = o_wready;
            @(posedge clk);
            #1;
            if (!rdy) stalls++;
            waitc++;
         end while (!rdy && waitc < 200);
         if (!rdy) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=stalled required=accept dest=%02h flit=%0d", dest, i);
         end else begin
            sent_log.push_back(d);
         end
         i_wvalid = 1'b0;
         if (maxgap > 0) idle($urandom_range(0, maxgap));
      end
   endtask

   initial begin
      int p0, p1, p2, s0;
      logic [7:0] dst;
      int sel;
      for (int k = 0; k < 3; k++) begin
         rr_mode[k] = 1;
         popped[k]  = 0;
      end
      i_reset  = 1'b1;
      i_wvalid = 1'b0;
      i_wdata  = '0;

      // Reset and idle
      idle(2);
      @(negedge clk);
      chk("reset_wready", 64'(o_wready), 64'd0);
      chk("reset_rvalid", 64'(rv), 64'd0);
      chk("reset_drop", 64'(o_drop_cnt), 64'd0);
      @(posedge clk);
      #1;
      i_reset = 1'b0;
      @(negedge clk);
      chk("release_wready", 64'(o_wready), 64'd1);
      @(posedge clk);
      #1;

      // Routing to port 1
      rr_mode[0] = 0; rr_mode[1] = 1; rr_mode[2] = 0;
      idle(1);
      p1 = popped[1]; stalls = 0;
      send_frame(8'h01, 3, 3, 0);
      idle(3);
      chk("route_p1_count", 64'(popped[1] - p1), 64'd3);
      chk("route_no_stall", 64'(stalls), 64'd0);

      // Backpressure on port 0
      rr_mode[0] = 0; rr_mode[1] = 1; rr_mode[2] = 1;
      idle(1);
      p0 = popped[0]; sent_log.delete();
      fork
         send_frame(8'h00, 4, 4, 0);
         begin
            repeat (6) @(negedge clk);
            chk("bp_wready", 64'(o_wready), 64'd0);
            chk("bp_rvalid0", 64'(o_rvalid0), 64'd1);
            chk("bp_head", 64'(o_rdata0), 64'(sent_log[0]));
            @(posedge clk);
            #1;
            rr_mode[0] = 1;
         end
      join
      idle(4);
      chk("bp_drained", 64'(popped[0] - p0), 64'd4);

      // Dropped frame followed by a port-2 frame
      rr_mode[0] = 1; rr_mode[1] = 1; rr_mode[2] = 1;
      idle(1);
      stalls = 0;
      send_frame(8'h7F, 3, 3, 0);
      chk("drop_no_stall", 64'(stalls), 64'd0);
      @(negedge clk);
      chk("drop_cnt_one", 64'(o_drop_cnt), 64'd1);
      chk("drop_no_valid", 64'(rv), 64'd0);
      @(posedge clk);
      #1;
      p2 = popped[2];
      send_frame(8'h02, 2, 2, 0);
      idle(3);
      chk("after_drop_p2", 64'(popped[2] - p2), 64'd2);

      // Back-to-back single-flit frames
      p0 = popped[0]; p1 = popped[1]; p2 = popped[2]; stalls = 0;
      send_frame(8'h00, 1, 1, 0);
      send_frame(8'h01, 1, 1, 0);
      send_frame(8'h02, 1, 1, 0);
      idle(3);
      chk("single_stalls", 64'(stalls), 64'd0);
      chk("single_each", 64'({8'(popped[0] - p0), 8'(popped[1] - p1), 8'(popped[2] - p2)}), 64'h010101);

      // Reset in the middle of a frame
      rr_mode[1] = 0;
      idle(1);
      send_frame(8'h01, 4, 2, 0);
      i_reset = 1'b1;
      idle(1);
      i_reset = 1'b0;
      @(negedge clk);
      chk("midrst_rvalid1", 64'(o_rvalid1), 64'd0);
      chk("midrst_drop", 64'(o_drop_cnt), 64'd0);
      @(posedge clk);
      #1;
      rr_mode[1] = 1;
      s0 = popped[1];
      send_frame(8'h01, 2, 2, 0);
      idle(3);
      chk("midrst_next", 64'(popped[1] - s0), 64'd2);

      // Random frames with random output backpressure
      for (int k = 0; k < 3; k++) rr_mode[k] = 2;
      for (int n = 0; n < 60; n++) begin
         sel = $urandom_range(0, 4);
         dst = (sel < 3) ? 8'(sel) : 8'($urandom_range(3, 255));
         send_frame(dst, $urandom_range(1, 5), 0, 0);
      end
      for (int n = 0; n < 60; n++) begin
         int len;
         sel = $urandom_range(0, 4);
         dst = (sel < 3) ? 8'(sel) : 8'($urandom_range(3, 255));
         len = $urandom_range(1, 5);
         send_frame(dst, len, len, $urandom_range(0, 2));
      end

      for (int k = 0; k < 3; k++) rr_mode[k] = 1;
      idle(10);
      @(negedge clk);
      chk("final_empty", 64'(rv), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
